// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment letter path: blank code,
// letter codes for the stored name and the sequencer state encoding.
package seg_pkg;

    localparam logic [3:0] BLANK = 4'hF;

    localparam logic [3:0] L_G = 4'd0;
    localparam logic [3:0] L_I = 4'd1;
    localparam logic [3:0] L_L = 4'd2;
    localparam logic [3:0] L_B = 4'd3;
    localparam logic [3:0] L_E = 4'd4;
    localparam logic [3:0] L_R = 4'd5;
    localparam logic [3:0] L_T = 4'd6;
    localparam logic [3:0] L_O = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    // The stored name is laid out so that the letter code equals its index.
    function automatic logic [3:0] letter_code(input logic [3:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/name_sequencer_tick_gen.sv
// Advance-tick source: programmable prescaler in auto mode, rising-edge
// detect on the debounced step button in manual mode.
module tick_gen
    import seg_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             manual,
    input  logic             step,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             step_q;
    logic             hit;

    // >= so that lowering div_i below the running count fires right away.
    assign hit  = (cnt >= div_i);
    assign tick = en & (manual ? (step & ~step_q) : hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= step;
            if (!en || manual || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/name_sequencer.sv
// Walks the seg7 decoder through the stored name, one letter per tick,
// with blank spaces between letters and a longer blank gap before repeating.
module name_sequencer
    import seg_pkg::*;
#(
    parameter int DIV_W       = 24,
    parameter int MSG_LEN     = 8,
    parameter int SPACE_TICKS = 1,
    parameter int GAP_TICKS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             manual,
    input  logic             step,
    input  logic [DIV_W-1:0] div_i,
    output logic [3:0]       digit_o,
    output logic [3:0]       idx_o,
    output logic             busy,
    output logic             wrap
);

    localparam int MAX_TICKS = (SPACE_TICKS > GAP_TICKS) ? SPACE_TICKS : GAP_TICKS;
    localparam int CW_RAW    = $clog2(MAX_TICKS + 1);
    localparam int CW        = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [CW-1:0] SPACE_LAST = CW'(SPACE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
    localparam logic [3:0]    LAST_IDX   = 4'(MSG_LEN - 1);

    state_t        state, state_n;
    logic [3:0]    idx_n;
    logic [CW-1:0] sg_cnt, sg_n;
    logic          wrap_n;
    logic          advance;
    logic          tick;

    // Prescaler stays parked at zero in IDLE so the first letter gets a full hold.
    tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (run && (state != IDLE)),
        .manual (manual),
        .step   (step),
        .div_i  (div_i),
        .tick   (tick)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx_o;
        sg_n    = sg_cnt;
        wrap_n  = 1'b0;
        advance = 1'b0;

        if (!run) begin
            state_n = IDLE;
            idx_n   = 4'd0;
            sg_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SHOW;
                    idx_n   = 4'd0;
                    sg_n    = '0;
                end
                SHOW: begin
                    if (tick) begin
                        if (SPACE_TICKS > 0) begin
                            state_n = SPACE;
                            sg_n    = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                SPACE: begin
                    if (tick) begin
                        if (sg_cnt == SPACE_LAST) advance = 1'b1;
                        else                      sg_n    = sg_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (sg_cnt == GAP_LAST) begin
                            state_n = SHOW;
                            sg_n    = '0;
                        end else begin
                            sg_n = sg_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = 4'd0;
                    sg_n    = '0;
                end
            endcase

            if (advance) begin
                sg_n = '0;
                if (idx_o < LAST_IDX) begin
                    idx_n   = idx_o + 4'd1;
                    state_n = SHOW;
                end else begin
                    idx_n   = 4'd0;
                    wrap_n  = 1'b1;
                    state_n = (GAP_TICKS > 0) ? GAP : SHOW;
                end
            end
        end
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx_o   <= 4'd0;
            sg_cnt  <= '0;
            digit_o <= BLANK;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_n;
            idx_o   <= idx_n;
            sg_cnt  <= sg_n;
            digit_o <= (state_n == SHOW) ? letter_code(idx_n) : BLANK;
            busy    <= (state_n != IDLE);
            wrap    <= wrap_n;
        end
    end

endmodule

// File: tb/tb_name_sequencer.sv
// Directed bench for name_sequencer: a vector table for reset and the auto
// div_i=0 sequence, plus hand-written multi-cycle corner cases.
module tb_name_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        manual;
    logic        step;
    logic [23:0] div_i;
    logic [3:0]  digit_o;
    logic [3:0]  idx_o;
    logic        busy;
    logic        wrap;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rst;
        logic        run;
        logic        manual;
        logic        step;
        logic [23:0] div;
        logic [3:0]  digit;
        logic [3:0]  idx;
        logic        busy;
        logic        wrap;
    } vec_t;

    vec_t tbl [0:39];

    name_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .manual  (manual),
        .step    (step),
        .div_i   (div_i),
        .digit_o (digit_o),
        .idx_o   (idx_o),
        .busy    (busy),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected symbol at position pos of the 18-symbol default cycle.
    function automatic logic [3:0] pat_digit(input int pos);
        if (pos < 16 && (pos % 2) == 0) return 4'(pos / 2);
        return 4'hF;
    endfunction

    function automatic logic [3:0] pat_idx(input int pos);
        if (pos < 16) return 4'(pos / 2);
        return 4'd0;
    endfunction

    task automatic do_reset(input logic m, input logic [23:0] d);
        rst    = 1'b1;
        run    = 1'b1;
        manual = m;
        step   = 1'b0;
        div_i  = d;
        tick_clk();
        tick_clk();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; manual = 1'b0; step = 1'b0; div_i = '0;

        for (int i = 0; i < 3; i++) begin
            tbl[i] = '{rst: 1'b1, run: 1'b1, manual: 1'b0, step: 1'b0, div: 24'd0,
                       digit: 4'hF, idx: 4'd0, busy: 1'b0, wrap: 1'b0};
        end
        for (int k = 1; k <= 37; k++) begin
            int pos;
            pos = (k - 1) % 18;
            tbl[k + 2] = '{rst: 1'b0, run: 1'b1, manual: 1'b0, step: 1'b0, div: 24'd0,
                           digit: pat_digit(pos), idx: pat_idx(pos), busy: 1'b1,
                           wrap: (pos == 16)};
        end

        for (int i = 0; i < 40; i++) begin
            rst = tbl[i].rst; run = tbl[i].run; manual = tbl[i].manual;
            step = tbl[i].step; div_i = tbl[i].div;
            tick_clk();
            chk($sformatf("v%0d_digit", i), {4'd0, digit_o}, {4'd0, tbl[i].digit});
            chk($sformatf("v%0d_idx", i),   {4'd0, idx_o},   {4'd0, tbl[i].idx});
            chk($sformatf("v%0d_busy", i),  {7'd0, busy},    {7'd0, tbl[i].busy});
            chk($sformatf("v%0d_wrap", i),  {7'd0, wrap},    {7'd0, tbl[i].wrap});
        end

        // Auto div_i=3: every symbol held 4 cycles, 72-cycle period.
        do_reset(1'b0, 24'd3);
        for (int k = 1; k <= 76; k++) begin
            int pos;
            tick_clk();
            pos = ((k - 1) / 4) % 18;
            chk($sformatf("d3_k%0d_digit", k), {4'd0, digit_o}, {4'd0, pat_digit(pos)});
            chk($sformatf("d3_k%0d_wrap", k), {7'd0, wrap},
                {7'd0, (pos == 16) && ((k - 1) % 4 == 0)});
        end

        // Manual: step held 5 cycles gives one advance.
        do_reset(1'b1, 24'd0);
        tick_clk();
        chk("man_start_digit", {4'd0, digit_o}, 8'h00);
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            chk($sformatf("man_hold%0d_digit", i), {4'd0, digit_o}, 8'h0F);
            chk($sformatf("man_hold%0d_idx", i),   {4'd0, idx_o},   8'h00);
        end
        step = 1'b0;
        tick_clk();
        chk("man_release_digit", {4'd0, digit_o}, 8'h0F);
        step = 1'b1;
        tick_clk();
        chk("man_next_digit", {4'd0, digit_o}, 8'h01);
        step = 1'b0;
        tick_clk();
        chk("man_next_hold", {4'd0, digit_o}, 8'h01);

        // Manual: nine single-cycle pulses from SHOW idx 0 land in SPACE after idx 4.
        do_reset(1'b1, 24'd0);
        tick_clk();
        for (int i = 0; i < 9; i++) begin
            step = 1'b1;
            tick_clk();
            step = 1'b0;
            tick_clk();
        end
        chk("nine_digit", {4'd0, digit_o}, 8'h0F);
        chk("nine_idx",   {4'd0, idx_o},   8'h04);
        chk("nine_busy",  {7'd0, busy},    8'h01);

        // run drop coincident with a tick in SHOW idx 5.
        do_reset(1'b0, 24'd0);
        for (int i = 0; i < 11; i++) tick_clk();
        chk("stop_pre_digit", {4'd0, digit_o}, 8'h05);
        run = 1'b0;
        tick_clk();
        chk("stop_digit", {4'd0, digit_o}, 8'h0F);
        chk("stop_idx",   {4'd0, idx_o},   8'h00);
        chk("stop_busy",  {7'd0, busy},    8'h00);
        chk("stop_wrap",  {7'd0, wrap},    8'h00);
        tick_clk();
        chk("stop_idle_busy", {7'd0, busy}, 8'h00);
        run = 1'b1;
        tick_clk();
        chk("restart_digit", {4'd0, digit_o}, 8'h00);
        chk("restart_busy",  {7'd0, busy},    8'h01);

        // div_i lowered below the running count fires at once.
        do_reset(1'b0, 24'd100);
        for (int i = 0; i < 51; i++) tick_clk();
        chk("div_pre_digit", {4'd0, digit_o}, 8'h00);
        div_i = 24'd2;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            chk($sformatf("div_space%0d", i), {4'd0, digit_o}, 8'h0F);
        end
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            chk($sformatf("div_show1_%0d", i), {4'd0, digit_o}, 8'h01);
        end
        tick_clk();
        chk("div_space_after", {4'd0, digit_o}, 8'h0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
